// File: rtl/mac_stream_reducer.sv
// Stream reducer: sums a fixed-length job of signed words from the MAC result
// stream, shifts and saturates the sum, and hands one result to the sink.
module mac_stream_reducer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       clear_i,
  input  logic                                       start_i,
  input  logic [CNT_WIDTH-1:0]                       len_i,
  input  logic [$clog2(DATA_WIDTH+CNT_WIDTH)-1:0]    shift_i,
  input  logic [DATA_WIDTH-1:0]                      d_data_i,
  input  logic                                       d_valid_i,
  output logic                                       d_ready_o,
  output logic [DATA_WIDTH-1:0]                      r_data_o,
  output logic                                       r_valid_o,
  input  logic                                       r_ready_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic [CNT_WIDTH-1:0]                       cnt_o
);

  localparam int unsigned ACC_W   = DATA_WIDTH + CNT_WIDTH;
  localparam int unsigned SHIFT_W = $clog2(ACC_W);
  localparam int unsigned TOP_W   = ACC_W - DATA_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]              state_q;
  logic [1:0]              state_n;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    d_ready_q;
  logic                    r_valid_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shr;
  logic [TOP_W-1:0]        top_bits;
  logic [DATA_WIDTH-1:0]   sat_c;
  logic                    d_hs;
  logic                    last_hs;

  assign d_hs    = d_valid_i && d_ready_q;
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign last_hs = d_hs && (cnt_inc == len_q);

  // Running sum including the word on the bus, shifted and clamped to the output range
  always_comb begin
    d_ext    = {{CNT_WIDTH{d_data_i[DATA_WIDTH-1]}}, d_data_i};
    acc_sum  = acc_q + d_ext;
    acc_shr  = acc_sum >>> shift_q;
    top_bits = acc_shr[ACC_W-1:DATA_WIDTH-1];
    if ((&top_bits) || !(|top_bits)) begin
      sat_c = acc_shr[DATA_WIDTH-1:0];
    end else if (acc_shr[ACC_W-1]) begin
      sat_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Next-state logic; clear forces IDLE regardless of any other event
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (start_i) state_n = (len_i != '0) ? ACC : OUT;
      ACC:  if (last_hs) state_n = OUT;
      OUT:  if (r_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear_i) state_n = IDLE;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Status flags registered from the next state so they line up with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      d_ready_q <= (state_n == ACC);
      busy_q    <= (state_n != IDLE);
    end
  end

  // Job parameters, accumulator, counter, result and done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q     <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        acc_q     <= '0;
        cnt_q     <= '0;
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              len_q   <= len_i;
              shift_q <= shift_i;
              acc_q   <= '0;
              cnt_q   <= '0;
              if (len_i == '0) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b1;
              end
            end
          end
          ACC: begin
            if (d_hs) begin
              acc_q <= acc_sum;
              cnt_q <= cnt_inc;
              if (last_hs) begin
                r_data_q  <= sat_c;
                r_valid_q <= 1'b1;
              end
            end
          end
          OUT: begin
            if (r_ready_i) begin
              r_valid_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign d_ready_o = d_ready_q;
  assign r_data_o  = r_data_q;
  assign r_valid_o = r_valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cnt_o     = cnt_q;

endmodule
